// File: rtl/cbfp_denorm.sv
// cbfp_denorm: restores fixed-point samples from 12-bit CBFP mantissas and per-block indices.
// Define CBFP_DENORM_SAT_EN to saturate out-of-range lanes; otherwise they wrap to OUT_W bits.
module cbfp_denorm #(
  parameter int NCHAN       = 16,
  parameter int BLOCK_SIZE  = 8,
  parameter int NBLOCKS     = NCHAN / BLOCK_SIZE,
  parameter int MANT_W      = 12,
  parameter int IN_W        = 25,
  parameter int IDX_W       = $clog2(IN_W),
  parameter int TRUNC_VALUE = 13,
  parameter int OUT_W       = 16,
  parameter int DROP_BITS   = 8,
  parameter int FRAME_BEATS = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [MANT_W-1:0] s_re [NCHAN],
  input  logic signed [MANT_W-1:0] s_im [NCHAN],
  input  logic [IDX_W-1:0]         s_idx [NBLOCKS],
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_re [NCHAN],
  output logic signed [OUT_W-1:0]  m_im [NCHAN],
  output logic                     m_last,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int R_W   = IN_W + 1 - DROP_BITS;
  localparam int CNT_W = $clog2(FRAME_BEATS);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(IN_W - 2);
  localparam logic [IDX_W-1:0]      TRUNC     = IDX_W'(TRUNC_VALUE);
  localparam logic signed [IN_W:0]  ROUND_ADD = (IN_W + 1)'(2 ** (DROP_BITS - 1));
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(FRAME_BEATS - 1);

  function automatic logic signed [IN_W-1:0] expand(input logic signed [MANT_W-1:0] mant,
                                                    input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0]       idx_c;
    logic signed [IN_W-1:0] ext;
    idx_c = (idx > IDX_MAX) ? IDX_MAX : idx;
    ext   = {{(IN_W - MANT_W){mant[MANT_W-1]}}, mant};
    if (idx_c <= TRUNC) return ext <<< (TRUNC - idx_c);
    else                return ext >>> (idx_c - TRUNC);
  endfunction

  // Round-half-up before dropping LSBs; one guard bit keeps the add from overflowing.
  function automatic logic signed [R_W-1:0] round_drop(input logic signed [IN_W-1:0] full);
    logic signed [IN_W:0] sum;
    sum = $signed({full[IN_W-1], full}) + ROUND_ADD;
    return R_W'(sum >>> DROP_BITS);
  endfunction

  function automatic logic out_of_range(input logic signed [R_W-1:0] r);
    return !((&r[R_W-1:OUT_W-1]) || !(|r[R_W-1:OUT_W-1]));
  endfunction

  function automatic logic signed [OUT_W-1:0] fit(input logic signed [R_W-1:0] r);
`ifdef CBFP_DENORM_SAT_EN
    if (!out_of_range(r)) return OUT_W'(r);
    else if (r[R_W-1])    return {1'b1, {(OUT_W - 1){1'b0}}};
    else                  return {1'b0, {(OUT_W - 1){1'b1}}};
`else
    return OUT_W'(r);
`endif
  endfunction

  logic                   v1_r, v2_r, ovf_r;
  logic [CNT_W-1:0]       beat_cnt_r;
  logic signed [IN_W-1:0] s1_re_r [NCHAN];
  logic signed [IN_W-1:0] s1_im_r [NCHAN];
  logic signed [IN_W-1:0] full_re_s [NCHAN];
  logic signed [IN_W-1:0] full_im_s [NCHAN];
  logic signed [R_W-1:0]  r_re_s [NCHAN];
  logic signed [R_W-1:0]  r_im_s [NCHAN];
  logic                   ovf_any_s, load2_s, accept_s, out_hs_s;

  assign s_ready    = !v1_r || !v2_r || m_ready;
  assign accept_s   = s_valid && s_ready;
  assign load2_s    = v1_r && (!v2_r || m_ready);
  assign out_hs_s   = v2_r && m_ready;
  assign m_valid    = v2_r;
  assign m_last     = v2_r && (beat_cnt_r == CNT_LAST);
  assign ovf_sticky = ovf_r;

  // Per-lane datapath: expansion for stage 1, rounding and range test for stage 2.
  always_comb begin
    ovf_any_s = 1'b0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      full_re_s[ch] = expand(s_re[ch], s_idx[ch / BLOCK_SIZE]);
      full_im_s[ch] = expand(s_im[ch], s_idx[ch / BLOCK_SIZE]);
      r_re_s[ch]    = round_drop(s1_re_r[ch]);
      r_im_s[ch]    = round_drop(s1_im_r[ch]);
      ovf_any_s     = ovf_any_s | out_of_range(r_re_s[ch]) | out_of_range(r_im_s[ch]);
    end
  end

  // Stage 1 register: holds the full-width reconstruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_r <= 1'b0;
      for (int ch = 0; ch < NCHAN; ch++) begin
        s1_re_r[ch] <= {IN_W{1'b0}};
        s1_im_r[ch] <= {IN_W{1'b0}};
      end
    end else begin
      if (s_ready) v1_r <= s_valid;
      if (accept_s) begin
        for (int ch = 0; ch < NCHAN; ch++) begin
          s1_re_r[ch] <= full_re_s[ch];
          s1_im_r[ch] <= full_im_s[ch];
        end
      end
    end
  end

  // Stage 2 register: output samples, held while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_r <= 1'b0;
      for (int ch = 0; ch < NCHAN; ch++) begin
        m_re[ch] <= {OUT_W{1'b0}};
        m_im[ch] <= {OUT_W{1'b0}};
      end
    end else begin
      if (!v2_r || m_ready) v2_r <= v1_r;
      if (load2_s) begin
        for (int ch = 0; ch < NCHAN; ch++) begin
          m_re[ch] <= fit(r_re_s[ch]);
          m_im[ch] <= fit(r_im_s[ch]);
        end
      end
    end
  end

  // Sticky overflow: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_r <= 1'b0;
    end else if (load2_s && ovf_any_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  // Frame position of the beat currently presented at the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      beat_cnt_r <= (beat_cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: directed cases plus randomized traffic against an
// arithmetic reference model and an in-order scoreboard.
module tb_cbfp_denorm;
  localparam int NCHAN = 16;

`ifdef CBFP_DENORM_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'hFFE0;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

  logic clk = 1'b0, rstn = 1'b1, s_valid = 1'b0, m_ready = 1'b0, ovf_clr = 1'b0;
  logic s_ready, m_valid, m_last, ovf_sticky;
  logic signed [11:0] s_re [NCHAN];
  logic signed [11:0] s_im [NCHAN];
  logic [4:0]         s_idx [2];
  logic signed [15:0] m_re [NCHAN];
  logic signed [15:0] m_im [NCHAN];

  cbfp_denorm dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_idx(s_idx),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_last(m_last), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] re;
    logic [255:0] im;
    logic         ovf;
    logic [31:0]  t;
  } beat_t;

  beat_t q[$];
  int    last_pos[$];
  int    n_vec = 0, n_err = 0, ncyc = 0, fcnt = 0, out_idx = 0;
  bit    ovf_m = 1'b0;

  function automatic longint fdiv(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  // Reference: value = mant * 2^(13-idx), rounded to 2^8 units, then saturated or wrapped.
  function automatic logic [15:0] ref_lane(input int mant, input int idx, output bit oor);
    int     ic;
    longint full, r;
    ic = (idx > 23) ? 23 : idx;
    if (ic <= 13) full = longint'(mant) * (longint'(1) << (13 - ic));
    else          full = fdiv(longint'(mant), longint'(1) << (ic - 13));
    r   = fdiv(full + 128, 256);
    oor = (r > 32767) || (r < -32768);
`ifdef CBFP_DENORM_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  function automatic beat_t make_exp();
    beat_t b;
    bit o1, o2;
    b.ovf = 1'b0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      b.re[ch*16 +: 16] = ref_lane(int'(s_re[ch]), int'(s_idx[ch / 8]), o1);
      b.im[ch*16 +: 16] = ref_lane(int'(s_im[ch]), int'(s_idx[ch / 8]), o2);
      b.ovf = b.ovf | o1 | o2;
    end
    b.t = 32'(ncyc);
    return b;
  endfunction

  function automatic logic [255:0] pack16(input logic signed [15:0] a [NCHAN]);
    logic [255:0] v;
    for (int ch = 0; ch < NCHAN; ch++) v[ch*16 +: 16] = a[ch];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int re_v, input int im_v, input int idx_v);
    for (int ch = 0; ch < NCHAN; ch++) begin
      s_re[ch] = 12'(re_v);
      s_im[ch] = 12'(im_v);
    end
    s_idx[0] = 5'(idx_v);
    s_idx[1] = 5'(idx_v);
  endtask

  task automatic rand_beat();
    for (int ch = 0; ch < NCHAN; ch++) begin
      s_re[ch] = 12'($urandom);
      s_im[ch] = 12'($urandom);
    end
    s_idx[0] = 5'($urandom_range(0, 31));
    s_idx[1] = 5'($urandom_range(0, 31));
  endtask

  // One clock: check outputs against the model, account for handshakes, advance the edge.
  task automatic step(output bit acc);
    bit mv, ohs, set, lst;
    int li;
    #1;
    mv  = (q.size() > 0) && (ncyc - int'(q[0].t) >= 2);
    lst = mv && (fcnt == 31);
    chk("s_ready", 256'(s_ready), 256'((q.size() < 2) || m_ready));
    chk("m_valid", 256'(m_valid), 256'(mv));
    chk("m_last", 256'(m_last), 256'(lst));
    chk("ovf_sticky", 256'(ovf_sticky), 256'(ovf_m));
    if (mv) begin
      chk("m_re", pack16(m_re), q[0].re);
      chk("m_im", pack16(m_im), q[0].im);
    end
    ohs = mv && m_ready;
    acc = s_valid && ((q.size() < 2) || m_ready);
    set = 1'b0;
    if (!mv || ohs) begin
      li = ohs ? 1 : 0;
      if (q.size() > li) set = q[li].ovf;
    end
    if (set) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    if (ohs) begin
      if (lst) last_pos.push_back(out_idx);
      out_idx++;
      void'(q.pop_front());
      fcnt = (fcnt + 1) % 32;
    end
    if (acc) q.push_back(make_exp());
    @(posedge clk);
    ncyc++;
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_m_valid", 256'(m_valid), 256'(0));
    chk("rst_m_last", 256'(m_last), 256'(0));
    chk("rst_ovf", 256'(ovf_sticky), 256'(0));
    chk("rst_m_re", pack16(m_re), 256'(0));
    q.delete();
    fcnt = 0;
    ovf_m = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    ncyc++;
    #1;
    rstn = 1'b1;
  endtask

  // One beat with m_ready high: explicit 2-cycle latency and lane value checks.
  task automatic directed(input string tag, input int re_v, input int im_v, input int idx_v,
                          input logic [15:0] exp_re, input logic [15:0] exp_im, input bit clr);
    bit a;
    set_all(re_v, im_v, idx_v);
    s_valid = 1'b1;
    m_ready = 1'b1;
    step(a);
    s_valid = 1'b0;
    ovf_clr = clr;
    step(a);
    ovf_clr = 1'b0;
    chk({tag, "_lat"}, 256'(m_valid), 256'(1));
    chk({tag, "_re"}, 256'($unsigned(m_re[0])), 256'(exp_re));
    chk({tag, "_im"}, 256'($unsigned(m_im[15])), 256'(exp_im));
  endtask

  initial begin
    bit a;
    int sent;
    set_all(0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    m_ready = 1'b1;
    step(a);

    directed("basic", 100, -100, 5, 16'd100, 16'hFF9C, 1'b0);
    chk("basic_ovf", 256'(ovf_sticky), 256'(0));
    step(a);
    directed("rshift", 1024, 1024, 20, 16'd0, 16'd0, 1'b0);
    step(a);
    directed("clamp", -2048, -2048, 31, 16'd0, 16'd0, 1'b0);
    step(a);
    directed("ovf_pos", 2047, 2047, 0, EXP_POS, EXP_POS, 1'b0);
    chk("ovf_set", 256'(ovf_sticky), 256'(1));
    step(a);
    ovf_clr = 1'b1;
    step(a);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 256'(ovf_sticky), 256'(0));
    directed("ovf_neg", -2048, -2048, 0, EXP_NEG, EXP_NEG, 1'b1);
    chk("set_beats_clr", 256'(ovf_sticky), 256'(1));
    step(a);

    // Backpressure: stall first to fill the pipe, clear the flag while stalled, then drain randomly.
    sent = 0;
    rand_beat();
    for (int k = 0; k < 300 && (sent < 10 || q.size() > 0); k++) begin
      s_valid = (sent < 10);
      m_ready = (k < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      ovf_clr = (k == 3);
      step(a);
      if (a) begin
        sent++;
        rand_beat();
      end
    end
    ovf_clr = 1'b0;
    chk("bp_done", 256'((sent == 10) && (q.size() == 0)), 256'(1));

    // Frame tagging over 70 back-to-back beats from a fresh frame.
    do_reset();
    m_ready = 1'b1;
    last_pos.delete();
    out_idx = 0;
    sent = 0;
    for (int k = 0; k < 100 && (sent < 70 || q.size() > 0); k++) begin
      rand_beat();
      s_valid = (sent < 70);
      step(a);
      if (a) sent++;
    end
    chk("frame_done", 256'((sent == 70) && (q.size() == 0)), 256'(1));
    chk("last_count", 256'(last_pos.size()), 256'(2));
    if (last_pos.size() == 2) begin
      chk("last_pos0", 256'(last_pos[0]), 256'(31));
      chk("last_pos1", 256'(last_pos[1]), 256'(63));
    end

    // Reset with two beats held in the stalled pipeline.
    m_ready = 1'b0;
    set_all(2047, -2048, 0);
    s_valid = 1'b1;
    step(a);
    step(a);
    step(a);
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) step(a);

    // Random traffic with random backpressure and clears.
    for (int k = 0; k < 400; k++) begin
      rand_beat();
      s_valid = 1'($urandom_range(0, 3) != 0);
      m_ready = 1'($urandom_range(0, 2) != 0);
      ovf_clr = 1'($urandom_range(0, 7) == 0);
      step(a);
    end
    s_valid = 1'b0;
    ovf_clr = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) step(a);
    chk("final_drain", 256'(q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cbfp_denorm.md
# cbfp_denorm

- Inverse of the CBFP normalizer: restores fixed-point samples from 12-bit block-floating-point mantissas and a per-block index.
- Sits at the FFT output, after the last CBFP stage, and feeds the 16-bit result/DAC path.
- Processes NCHAN lanes (re/im) per beat through a 2-stage elastic pipeline with valid/ready handshake.
- Provides frame-boundary tagging and a sticky overflow flag.

## Interface
- NCHAN, 16, lanes per beat
- BLOCK_SIZE, 8, lanes sharing one index
- NBLOCKS, NCHAN/BLOCK_SIZE, indices per beat
- MANT_W, 12, input mantissa width <6.6>
- IN_W, 25, normalizer input width <12.13>
- IDX_W, $clog2(IN_W), index width
- TRUNC_VALUE, 13, normalizer truncation constant
- OUT_W, 16, output width
- DROP_BITS, 8, LSBs dropped (rounded) from the IN_W reconstruction
- FRAME_BEATS, 32, beats per FFT frame
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_re / s_im  in  [NCHAN] x MANT_W signed  mantissas
- s_idx  in  [NBLOCKS] x IDX_W unsigned  block index (lane ch uses s_idx[ch/BLOCK_SIZE])
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_re / m_im  out  [NCHAN] x OUT_W signed  restored samples
- m_last  out  1  last beat of frame
- ovf_sticky  out  1  any saturation/wrap since clear
- ovf_clr  in  1  synchronous clear of ovf_sticky

## Operation
- Accept a beat when s_valid && s_ready.
- Index clamp: idx_c = min(s_idx, IN_W-2), i.e. 23 at defaults.
- Stage 1 (registered), full IN_W-bit value:
  - idx_c <= TRUNC_VALUE: full = sext(mant) <<< (TRUNC_VALUE - idx_c)
  - otherwise: full = sext(mant) >>> (idx_c - TRUNC_VALUE), arithmetic floor.
  - The full value never overflows IN_W.
- Stage 2 (registered):
  - r = (full + 2^(DROP_BITS-1)) >>> DROP_BITS, computed at IN_W+1 bits.
  - Fit r to OUT_W bits according to the Configuration macro.
  - A lane is out of range when r is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Overflow flag:
  - Any out-of-range lane (re or im) in a beat sets ovf_sticky when that beat is loaded into stage 2.
  - ovf_clr clears ovf_sticky. If a set and ovf_clr occur in the same cycle, set wins.
- Frame counter:
  - beat_cnt counts output handshakes (m_valid && m_ready), modulo FRAME_BEATS.
  - m_last = m_valid && (beat_cnt == FRAME_BEATS-1).
  - The counter wraps to 0 after the last beat.
- Pipeline control:
  - Each stage holds a valid bit and loads when it is empty or its contents are advancing.
  - s_ready = !v1 || !v2 || m_ready. This is combinational from m_ready; there is no path from s_valid to s_ready.
  - Output data and m_last hold stable while m_valid && !m_ready.
- Reset (asynchronous): v1 = v2 = 0, m_valid = 0, m_last = 0, m_re/m_im = 0, ovf_sticky = 0, beat_cnt = 0, s_ready = 1 after release.
  - Reset mid-frame discards in-flight beats and restarts the frame count.

## Timing
- Latency: 2 cycles from accept to m_valid, with m_ready held high.
- Throughput: 1 beat/cycle sustained while m_ready = 1.
- Stall behaviour:
  - With m_ready = 0 the pipeline fills 2 beats, then s_ready drops.
  - No beat is lost or duplicated.
  - On m_ready rising, the beats drain in order.
- Simultaneous cases:
  - Input accept and output handshake in the same cycle with a full pipeline: both proceed.
  - ovf_clr while stalled: clears the flag; held data is unchanged.

## Configuration
- CBFP_DENORM_SAT_EN defined:
  - Out-of-range r saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
  - ovf_sticky set as specified.
- Not defined:
  - r is truncated to its low OUT_W bits (two's-complement wrap).
  - ovf_sticky still reports out-of-range events.

## Test plan
- Basic restore: mant re=100, im=-100, idx=5, m_ready=1 -> m_re=100, m_im=-100 exactly 2 cycles after accept; ovf_sticky=0.
- Right shift and index clamp:
  - mant=1024, idx=20 -> full=8, m_re=0.
  - idx=31 clamped to 23, mant=-2048 -> full=-2, m_re=0 (-2+128, >>>8 = 0).
- Overflow, idx=0, mant=2047:
  - SAT_EN defined -> m_re=32767, ovf_sticky=1.
  - Not defined -> m_re=-32.
  - mant=-2048 with SAT_EN -> m_re=-32768.
- Backpressure:
  - Stream 10 beats with m_ready toggling randomly -> all 10 outputs in order, unchanged while stalled.
  - s_ready=0 only when 2 beats are held and m_ready=0.
- Frame tagging: 70 consecutive beats -> m_last on output beats 31 and 63 only; counter resumes at 0.
- Reset and clear:
  - rstn asserted with 2 beats in flight -> m_valid=0 immediately, no stale output after release.
  - ovf_clr coincident with a new overflow -> ovf_sticky stays 1.
